// File: rtl/zap_cp_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// zap_cp_issue_unit_pkg
// Shared definitions for the coprocessor issue unit:
//   - cp_state_t       : issue FSM state encoding
//   - CP_WORD_W        : coprocessor instruction word width
//   - CP_DUMMY_REG_DEFAULT : default physical index of the write-sink register
//   - field helpers    : CP number [11:8], L bit [20], CRn [19:16], Rd [15:12]
// -----------------------------------------------------------------------------
package zap_cp_issue_unit_pkg;

  localparam int unsigned CP_WORD_W            = 32;
  localparam int unsigned CP_DUMMY_REG_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_TRAP  = 3'd4
  } cp_state_t;

  // Coprocessor number addressed by an MCR/MRC word.
  function automatic logic [3:0] cp_num(input logic [CP_WORD_W-1:0] word);
    return word[11:8];
  endfunction

  // L bit: 1 = MRC (coprocessor to core), 0 = MCR.
  function automatic logic cp_is_mrc(input logic [CP_WORD_W-1:0] word);
    return word[20];
  endfunction

  function automatic logic [3:0] cp_crn(input logic [CP_WORD_W-1:0] word);
    return word[19:16];
  endfunction

  function automatic logic [3:0] cp_rd(input logic [CP_WORD_W-1:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/zap_cp_issue_unit_if.sv
// -----------------------------------------------------------------------------
// zap_cp_issue_unit_if
// Coprocessor bus between the core-side issue unit (master) and the
// coprocessors (slave).
//   cp_word / cp_dav        : instruction word and its valid, core -> cp
//   cp_done                 : completion pulse, cp -> core
//   cp_reg_en               : register-file access strobe, cp -> core
//   cp_reg_wr_index/_data   : register write request, cp -> core
//   cp_reg_rd_index         : register read request, cp -> core
//   cp_reg_rd_data          : read data (one cycle latency), core -> cp
// -----------------------------------------------------------------------------
interface zap_cp_issue_unit_if #(
  parameter int unsigned IDX_W = 6
);
  logic [31:0]      cp_word;
  logic             cp_dav;
  logic             cp_done;
  logic             cp_reg_en;
  logic [IDX_W-1:0] cp_reg_wr_index;
  logic [31:0]      cp_reg_wr_data;
  logic [IDX_W-1:0] cp_reg_rd_index;
  logic [31:0]      cp_reg_rd_data;

  modport master (
    output cp_word, cp_dav, cp_reg_rd_data,
    input  cp_done, cp_reg_en, cp_reg_wr_index, cp_reg_wr_data, cp_reg_rd_index
  );

  modport slave (
    input  cp_word, cp_dav, cp_reg_rd_data,
    output cp_done, cp_reg_en, cp_reg_wr_index, cp_reg_wr_data, cp_reg_rd_index
  );
endinterface

// File: rtl/zap_cp_wdog.sv
// -----------------------------------------------------------------------------
// zap_cp_wdog
// Timeout counter for a coprocessor operation in flight. Only instantiated
// when ZAP_CP_TIMEOUT_EN is defined.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the counter (issue cycle)
//   i_enable       : count this cycle (waiting on the coprocessor)
//   o_expire_c     : combinational, high on the TIMEOUT_CYCLES-th enabled cycle
// -----------------------------------------------------------------------------
module zap_cp_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  assign o_expire_c = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count enabled cycles; hold at the terminal value once expired.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire_c) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zap_cp_issue_unit.sv
// -----------------------------------------------------------------------------
// zap_cp_issue_unit
// Core-side initiator of the coprocessor bus. Takes an MCR/MRC from the issue
// stage, stalls the pipeline, presents the word with dav, waits for done, and
// meanwhile serves the coprocessor's register-file accesses.
//
// Optional build macro: ZAP_CP_TIMEOUT_EN -- trap an unresponsive coprocessor
// after TIMEOUT_CYCLES cycles in WAIT (otherwise WAIT lasts until done).
//
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_instr, i_instr_valid : coprocessor instruction from the issue stage
//   i_flush                : pipeline flush (honoured in IDLE/ISSUE only)
//   o_stall                : combinational, hold the issue stage
//   o_retire, o_und        : one-cycle completion / undefined-trap pulses
//   cp                     : coprocessor bus (master side)
//   o_rf_wr_*              : register-file write port (registered)
//   o_rf_rd_index          : register-file read index (combinational)
//   i_rf_rd_data           : register-file read data
// -----------------------------------------------------------------------------
module zap_cp_issue_unit
  import zap_cp_issue_unit_pkg::*;
#(
  parameter int unsigned PHY_REGS        = 64,
  parameter int unsigned DUMMY_REG       = CP_DUMMY_REG_DEFAULT,
  parameter logic [15:0] CP_PRESENT_MASK = 16'h8000,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  localparam int unsigned IDX_W          = $clog2(PHY_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CP_WORD_W-1:0] i_instr,
  input  logic                 i_instr_valid,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_retire,
  output logic                 o_und,
  zap_cp_issue_unit_if.master  cp,
  output logic                 o_rf_wr_en,
  output logic [IDX_W-1:0]     o_rf_wr_index,
  output logic [31:0]          o_rf_wr_data,
  output logic [IDX_W-1:0]     o_rf_rd_index,
  input  logic [31:0]          i_rf_rd_data
);

  cp_state_t            r_state;
  logic [CP_WORD_W-1:0] r_cp_word;
  logic                 r_cp_dav;
  logic                 r_retire;
  logic                 r_und;
  logic                 r_rf_wr_en;
  logic [IDX_W-1:0]     r_rf_wr_index;
  logic [31:0]          r_rf_wr_data;
  logic [31:0]          r_cp_reg_rd_data;

  logic                 w_present;
  logic                 w_in_wait;
  logic                 w_wr_fire;
  logic                 w_timeout;

  assign w_present = CP_PRESENT_MASK[cp_num(i_instr)];
  assign w_in_wait = (r_state == ST_WAIT);
  // Writes to the sink register are dropped rather than forwarded.
  assign w_wr_fire = w_in_wait && cp.cp_reg_en &&
                     (cp.cp_reg_wr_index != IDX_W'(DUMMY_REG));

`ifdef ZAP_CP_TIMEOUT_EN
  logic w_wd_clear;
  assign w_wd_clear = (r_state == ST_ISSUE);

  zap_cp_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_wd_clear),
    .i_enable   (w_in_wait),
    .o_expire_c (w_timeout)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // Stall: pending request in IDLE, always while an op is in flight.
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      ST_IDLE:           o_stall = i_instr_valid;
      ST_ISSUE, ST_WAIT: o_stall = 1'b1;
      default:           o_stall = 1'b0;
    endcase
  end

  // Read index is only exposed while a coprocessor owns the port.
  assign o_rf_rd_index = w_in_wait ? cp.cp_reg_rd_index : '0;

  // Issue FSM with registered bus and register-port outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_cp_word        <= '0;
      r_cp_dav         <= 1'b0;
      r_retire         <= 1'b0;
      r_und            <= 1'b0;
      r_rf_wr_en       <= 1'b0;
      r_rf_wr_index    <= '0;
      r_rf_wr_data     <= '0;
      r_cp_reg_rd_data <= '0;
    end else begin
      r_retire         <= 1'b0;
      r_und            <= 1'b0;
      r_rf_wr_en       <= w_wr_fire;
      r_cp_reg_rd_data <= i_rf_rd_data;

      if (w_wr_fire) begin
        r_rf_wr_index <= cp.cp_reg_wr_index;
        r_rf_wr_data  <= cp.cp_reg_wr_data;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_instr_valid && !i_flush) begin
            r_cp_word <= i_instr;
            r_state   <= w_present ? ST_ISSUE : ST_TRAP;
          end
        end
        ST_ISSUE: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_cp_dav <= 1'b1;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Done takes priority over a simultaneous timeout.
          if (cp.cp_done) begin
            r_cp_dav <= 1'b0;
            r_state  <= ST_DONE;
          end else if (w_timeout) begin
            r_cp_dav <= 1'b0;
            r_state  <= ST_TRAP;
          end
        end
        ST_DONE: begin
          r_retire <= 1'b1;
          r_state  <= ST_IDLE;
        end
        ST_TRAP: begin
          r_und    <= 1'b1;
          r_cp_dav <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_cp_dav <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign cp.cp_word        = r_cp_word;
  assign cp.cp_dav         = r_cp_dav;
  assign cp.cp_reg_rd_data = r_cp_reg_rd_data;
  assign o_retire          = r_retire;
  assign o_und             = r_und;
  assign o_rf_wr_en        = r_rf_wr_en;
  assign o_rf_wr_index     = r_rf_wr_index;
  assign o_rf_wr_data      = r_rf_wr_data;

endmodule

// File: doc/zap_cp_issue_unit.md
Name: zap_cp_issue_unit

Overview:
Core-side initiator of the coprocessor bus.
- Accepts MCR/MRC instructions from the issue stage and stalls the pipeline.
- Presents the instruction word to coprocessors with a valid (dav) handshake and waits for the done pulse.
- Meanwhile arbitrates the register-file port to the coprocessor: forwards its writes and returns its reads.
- Raises an undefined-instruction trap for absent coprocessors or, optionally, an unresponsive one.

Parameters:
PHY_REGS, 64, physical register count; index width is $clog2(PHY_REGS).
DUMMY_REG, 16, physical index that is a write sink; writes to it are discarded.
CP_PRESENT_MASK, 16'h8000, bit n = 1 means coprocessor n is present (default: CP15 only).
TIMEOUT_CYCLES, 64, cycles in WAIT before a timeout trap (used only with CP_TIMEOUT_EN).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_instr  in  32  coprocessor instruction from issue stage
i_instr_valid  in  1  i_instr is an MCR/MRC to execute
i_flush  in  1  pipeline flush
o_stall  out  1  hold issue stage
o_retire  out  1  one-cycle pulse: instruction completed
o_und  out  1  one-cycle pulse: undefined-instruction trap
o_cp_word  out  32  instruction word to coprocessors
o_cp_dav  out  1  o_cp_word valid
i_cp_done  in  1  coprocessor done pulse
i_cp_reg_en  in  1  coprocessor register access strobe
i_cp_reg_wr_index  in  $clog2(PHY_REGS)  coprocessor write index
i_cp_reg_wr_data  in  32  coprocessor write data
i_cp_reg_rd_index  in  $clog2(PHY_REGS)  coprocessor read index
o_cp_reg_rd_data  out  32  read data returned to coprocessor
o_rf_wr_en  out  1  register-file write enable
o_rf_wr_index  out  $clog2(PHY_REGS)  register-file write index
o_rf_wr_data  out  32  register-file write data
o_rf_rd_index  out  $clog2(PHY_REGS)  register-file read index
i_rf_rd_data  in  32  register-file read data (combinational on o_rf_rd_index)

Behaviour:
Reset values: all outputs 0, state IDLE, timeout counter 0.

States are IDLE, ISSUE, WAIT, DONE, TRAP.
- IDLE: o_stall = i_instr_valid (combinational).
  - If valid and !i_flush: latch i_instr into o_cp_word.
  - If CP_PRESENT_MASK[i_instr[11:8]] is set, go to ISSUE; otherwise go to TRAP.
- ISSUE: o_cp_dav <= 1, go to WAIT, clear the timeout counter.
  - i_flush in ISSUE: return to IDLE with dav never asserted.
- WAIT: o_stall = 1; o_cp_word held stable; i_flush ignored (coprocessor ops are not abortable).
  - On i_cp_done: o_cp_dav <= 0 (registered, so dav is low on the cycle after done is seen), go to DONE.
- DONE: o_retire <= 1 for one cycle, o_stall = 0, go to IDLE.
- TRAP: o_und <= 1 for one cycle, o_stall = 0, o_cp_dav = 0, go to IDLE.

Done handling:
- i_cp_done is honoured only in WAIT and ignored in every other state. This covers the duplicate done pulse a responder emits when it rejects a USR-mode access while dav is still high.

Register port, active in WAIT only:
- o_rf_wr_en = i_cp_reg_en && (i_cp_reg_wr_index != DUMMY_REG), registered one cycle; index and data are registered alongside.
- o_rf_rd_index = i_cp_reg_rd_index, passed through combinationally.
- o_cp_reg_rd_data <= i_rf_rd_data every cycle, giving one cycle of latency. This meets responders that sample read data two cycles after asserting reg_en.
- Outside WAIT, i_cp_reg_en is ignored and o_rf_wr_en = 0.

Boundary conditions:
- Done and timeout in the same cycle: done wins.
- Back-to-back instructions: the next one is accepted in the IDLE cycle after DONE, so dav is low for at least 2 cycles between ops.
- Reset in any state: immediate return to IDLE with dav dropped.

Optional Feature:
ZAP_CP_TIMEOUT_EN
- Defined: a counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without done, drop dav and go to TRAP (o_und pulse).
- Undefined: no counter; WAIT persists until i_cp_done.

Decomposition:
- Shared header (cp_bus.vh): state encodings, CP number field [11:8], L bit [20], CRn [19:16], Rd [15:12], DUMMY_REG default.
- One sub-module, zap_cp_wdog: timeout counter with clear/enable/expire, instantiated only under ZAP_CP_TIMEOUT_EN.

Test Plan:
- MRC p15 (word 0xEE110F10), responder done 4 cycles after dav -> dav high 4 cycles, low the cycle after done, o_retire one cycle later, o_stall released.
- MCR p15 with responder reg_en, rd_index=3, wr_index=16, i_rf_rd_data=0xDEADBEEF -> o_cp_reg_rd_data=0xDEADBEEF next cycle, o_rf_wr_en stays 0.
- MRC with reg_en, wr_index=5, data 0x00000F00 -> o_rf_wr_en pulse, index 5, data 0x00000F00.
- Instruction to CP14 (i_instr[11:8]=14) with default mask -> o_und pulse within 2 cycles, o_cp_dav never asserted.
- USR-mode op: two done pulses 2 cycles apart -> exactly one o_retire; the second pulse is ignored.
- ZAP_CP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> o_und after 8 WAIT cycles, dav low; reset asserted mid-WAIT -> all outputs 0 the next cycle.
